fco_bitslip_ctrl: RTL and testbench



---
 rtl/fco_bitslip_ctrl.sv | 130 +++++++++++++
 tb/tb_fco_bitslip_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fco_bitslip_ctrl.sv
// Frame-alignment sequencer: issues one-position bitslip pulses until the FCO monitor locks.
// Optional build macro FCO_BITSLIP_AUTO_RELOCK_EN: lock loss restarts the search instead of failing.
module fco_bitslip_ctrl #(
    parameter int unsigned SLIP_MAX      = 16,
    parameter int unsigned SETTLE_WORDS  = 8,
    parameter int unsigned TIMEOUT_WORDS = 256,
    parameter int unsigned ERR_W         = 16
) (
    input  logic             dco_clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             word_valid,
    input  logic             aligned,
    input  logic             align_err_pulse,
    output logic             bitslip,
    output logic             busy,
    output logic             locked,
    output logic             fail,
    output logic [7:0]       slip_count,
    output logic [ERR_W-1:0] lost_count,
    output logic [2:0]       state
);

    localparam int unsigned WMAX   = (SETTLE_WORDS > TIMEOUT_WORDS) ? SETTLE_WORDS : TIMEOUT_WORDS;
    localparam int unsigned WCNT_W = $clog2(WMAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_WAIT   = 3'd2,
        ST_SLIP   = 3'd3,
        ST_LOCKED = 3'd4,
        ST_FAIL   = 3'd5
    } state_t;

    state_t            st_q, st_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [7:0]        slip_d;
    logic [ERR_W-1:0]  lost_d;
    logic              pos_bad;

    // Next-state and counter updates; start overrides every other event.
    always_comb begin
        st_d    = st_q;
        wcnt_d  = wcnt_q;
        slip_d  = slip_count;
        lost_d  = lost_count;
        pos_bad = 1'b0;
        if (start) begin
            st_d   = ST_SETTLE;
            wcnt_d = '0;
            slip_d = '0;
        end else begin
            case (st_q)
                ST_SETTLE: begin
                    if (word_valid) begin
                        if (wcnt_q == WCNT_W'(SETTLE_WORDS - 1)) begin
                            st_d   = ST_WAIT;
                            wcnt_d = '0;
                        end else begin
                            wcnt_d = wcnt_q + WCNT_W'(1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (align_err_pulse) begin
                        pos_bad = 1'b1;
                    end else if (aligned) begin
                        st_d = ST_LOCKED;
                    end else if (word_valid) begin
                        if (wcnt_q == WCNT_W'(TIMEOUT_WORDS - 1)) begin
                            pos_bad = 1'b1;
                        end else begin
                            wcnt_d = wcnt_q + WCNT_W'(1);
                        end
                    end
                    if (pos_bad) begin
                        st_d = (slip_count == 8'(SLIP_MAX - 1)) ? ST_FAIL : ST_SLIP;
                    end
                end
                ST_SLIP: begin
                    st_d   = ST_SETTLE;
                    wcnt_d = '0;
                    slip_d = slip_count + 8'd1;
                end
                ST_LOCKED: begin
                    if (!aligned || align_err_pulse) begin
                        if (lost_count != '1) begin
                            lost_d = lost_count + ERR_W'(1);
                        end
`ifdef FCO_BITSLIP_AUTO_RELOCK_EN
                        st_d   = ST_SETTLE;
                        wcnt_d = '0;
                        slip_d = '0;
`else
                        st_d   = ST_FAIL;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered state, counters and decoded status outputs.
    always_ff @(posedge dco_clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q       <= ST_IDLE;
            wcnt_q     <= '0;
            slip_count <= '0;
            lost_count <= '0;
            bitslip    <= 1'b0;
            busy       <= 1'b0;
            locked     <= 1'b0;
            fail       <= 1'b0;
        end else begin
            st_q       <= st_d;
            wcnt_q     <= wcnt_d;
            slip_count <= slip_d;
            lost_count <= lost_d;
            bitslip    <= (st_d == ST_SLIP);
            busy       <= (st_d == ST_SETTLE) || (st_d == ST_WAIT) || (st_d == ST_SLIP);
            locked     <= (st_d == ST_LOCKED);
            fail       <= (st_d == ST_FAIL);
        end
    end

    assign state = st_q;

endmodule

// File: tb/tb_fco_bitslip_ctrl.sv
// Bench for fco_bitslip_ctrl: two parameterisations driven in parallel against a countdown model.
module tb_fco_bitslip_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, word_valid = 1'b0, aligned = 1'b0, align_err_pulse = 1'b0;

    logic        a_bitslip, a_busy, a_locked, a_fail;
    logic [7:0]  a_slip;
    logic [15:0] a_lost;
    logic [2:0]  a_state;
    logic        b_bitslip, b_busy, b_locked, b_fail;
    logic [7:0]  b_slip;
    logic [15:0] b_lost;
    logic [2:0]  b_state;

    always #5 clk = ~clk;

    fco_bitslip_ctrl dut_a (
        .dco_clk(clk), .rst_n(rst_n), .start(start), .word_valid(word_valid),
        .aligned(aligned), .align_err_pulse(align_err_pulse),
        .bitslip(a_bitslip), .busy(a_busy), .locked(a_locked), .fail(a_fail),
        .slip_count(a_slip), .lost_count(a_lost), .state(a_state)
    );

    fco_bitslip_ctrl #(.SLIP_MAX(4), .SETTLE_WORDS(8), .TIMEOUT_WORDS(16), .ERR_W(16)) dut_b (
        .dco_clk(clk), .rst_n(rst_n), .start(start), .word_valid(word_valid),
        .aligned(aligned), .align_err_pulse(align_err_pulse),
        .bitslip(b_bitslip), .busy(b_busy), .locked(b_locked), .fail(b_fail),
        .slip_count(b_slip), .lost_count(b_lost), .state(b_state)
    );

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Model: phase plus "valid words still to wait" countdown.
    typedef struct {
        int ph;     // 0 idle,1 settle,2 wait,3 slip,4 locked,5 fail
        int slips;
        int left;
        int lost;
    } mdl_t;

    function automatic mdl_t mreset();
        mdl_t m;
        m.ph = 0; m.slips = 0; m.left = 0; m.lost = 0;
        return m;
    endfunction

    function automatic mdl_t mstep(mdl_t m, int smax, int settle, int tmo,
                                   logic s, logic wv, logic al, logic er);
        mdl_t n = m;
        bit bad = 0;
        if (s) begin
            n.ph = 1; n.slips = 0; n.left = settle;
            return n;
        end
        case (m.ph)
            1: if (wv) begin
                n.left = m.left - 1;
                if (n.left == 0) begin n.ph = 2; n.left = tmo; end
            end
            2: begin
                if (er) bad = 1;
                else if (al) n.ph = 4;
                else if (wv) begin
                    n.left = m.left - 1;
                    if (n.left == 0) bad = 1;
                end
                if (bad) n.ph = (m.slips == smax - 1) ? 5 : 3;
            end
            3: begin n.ph = 1; n.slips = m.slips + 1; n.left = settle; end
            4: if (!al || er) begin
                if (m.lost < 65535) n.lost = m.lost + 1;
`ifdef FCO_BITSLIP_AUTO_RELOCK_EN
                n.ph = 1; n.slips = 0; n.left = settle;
`else
                n.ph = 5;
`endif
            end
            default: ;
        endcase
        return n;
    endfunction

    mdl_t ma, mb;
    int cyc = 0;
    int pa = 0, pb = 0, last_a = 0, last_b = 0, gap_a = 0, gap_b = 0;

    // Single compare process: advance models at each edge, check both DUTs just after.
    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            ma = mreset(); mb = mreset();
        end else begin
            ma = mstep(ma, 16, 8, 256, start, word_valid, aligned, align_err_pulse);
            mb = mstep(mb, 4, 8, 16, start, word_valid, aligned, align_err_pulse);
        end
        #1;
        cyc++;
        chk("a.state", a_state, ma.ph);
        chk("a.bitslip", a_bitslip, ma.ph == 3);
        chk("a.busy", a_busy, ma.ph >= 1 && ma.ph <= 3);
        chk("a.locked", a_locked, ma.ph == 4);
        chk("a.fail", a_fail, ma.ph == 5);
        chk("a.slip_count", a_slip, ma.slips);
        chk("a.lost_count", a_lost, ma.lost);
        chk("b.state", b_state, mb.ph);
        chk("b.bitslip", b_bitslip, mb.ph == 3);
        chk("b.busy", b_busy, mb.ph >= 1 && mb.ph <= 3);
        chk("b.locked", b_locked, mb.ph == 4);
        chk("b.fail", b_fail, mb.ph == 5);
        chk("b.slip_count", b_slip, mb.slips);
        chk("b.lost_count", b_lost, mb.lost);
        if (a_bitslip) begin pa++; gap_a = cyc - last_a; last_a = cyc; end
        if (b_bitslip) begin pb++; gap_b = cyc - last_b; last_b = cyc; end
    end

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    initial begin
        int p0, q0, n;
        bit hit;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst.state", a_state, 0);
        chk("rst.busy", a_busy, 0);
        chk("rst.bitslip", a_bitslip, 0);
        rst_n = 1'b1;
        word_valid = 1'b1;

        // Lock after 3 words in WAIT_LOCK, no slips
        p0 = pa;
        pulse_start();
        repeat (10) @(negedge clk);
        aligned = 1'b1;
        repeat (3) @(negedge clk);
        chk("t1.locked", a_locked, 1);
        chk("t1.slip_count", a_slip, 0);
        chk("t1.pulses", pa - p0, 0);

        // Lock loss
        aligned = 1'b0;
        @(negedge clk);
        chk("t1b.lost_count", a_lost, 1);
`ifdef FCO_BITSLIP_AUTO_RELOCK_EN
        chk("t1b.state", a_state, 1);
        chk("t1b.slip_count", a_slip, 0);
`else
        chk("t1b.fail", a_fail, 1);
`endif

        // Error at each position, lock after the 5th slip
        align_err_pulse = 1'b1;
        p0 = pa;
        pulse_start();
        hit = 0;
        for (n = 0; n < 200; n++) begin
            if (pa - p0 == 5) begin hit = 1; break; end
            @(negedge clk);
        end
        chk("t2.reach5", hit, 1);
        align_err_pulse = 1'b0;
        aligned = 1'b1;
        repeat (12) @(negedge clk);
        chk("t2.locked", a_locked, 1);
        chk("t2.slip_count", a_slip, 5);
        chk("t2.pulses", pa - p0, 5);
        chk("t2.gap", gap_a, 10);
        chk("t2.b_fail", b_fail, 1);

        // Timeouts exhaust the small instance
        aligned = 1'b0;
        q0 = pb;
        pulse_start();
        hit = 0;
        for (n = 0; n < 300; n++) begin
            if (b_fail) begin hit = 1; break; end
            @(negedge clk);
        end
        chk("t3.b_fail", hit, 1);
        chk("t3.b_slip_count", b_slip, 3);
        chk("t3.b_pulses", pb - q0, 3);
        chk("t3.b_gap", gap_b, 25);

        // start coincident with align_err_pulse in WAIT_LOCK
        pulse_start();
        hit = 0;
        for (n = 0; n < 30; n++) begin
            if (a_state == 3'd2) begin hit = 1; break; end
            @(negedge clk);
        end
        chk("t4.reach_wait", hit, 1);
        start = 1'b1; align_err_pulse = 1'b1;
        @(negedge clk);
        start = 1'b0; align_err_pulse = 1'b0;
        chk("t4.state", a_state, 1);
        chk("t4.bitslip", a_bitslip, 0);

        // word_valid gap in SETTLE
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        word_valid = 1'b0;
        repeat (50) @(negedge clk);
        chk("t5.hold_state", a_state, 1);
        word_valid = 1'b1;
        repeat (4) @(negedge clk);
        chk("t5.not_yet", a_state, 1);
        @(negedge clk);
        chk("t5.resume", a_state, 2);

        // Async reset in the middle of a SLIP cycle
        align_err_pulse = 1'b1;
        pulse_start();
        hit = 0;
        for (n = 0; n < 30; n++) begin
            if (a_bitslip) begin hit = 1; break; end
            @(negedge clk);
        end
        chk("t6.saw_slip", hit, 1);
        rst_n = 1'b0;
        #1;
        chk("t6.bitslip", a_bitslip, 0);
        chk("t6.state", a_state, 0);
        chk("t6.busy", a_busy, 0);
        chk("t6.slip_count", a_slip, 0);
        chk("t6.lost_count", a_lost, 0);
        align_err_pulse = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
